// File: rtl/warp_scheduler_pkg.sv
// ============================================================================
//  Module      : warp_scheduler_pkg
//  Description : Shared types for the warp scheduler. Defines the pipeline
//                stage broadcast to the register files, the scheduler's
//                internal state encoding, and helpers that map one to the
//                other.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package warp_scheduler_pkg;

    localparam int DATA_W = `DATA_WIDTH;

    typedef logic [DATA_W-1:0] data_t;

    // Stage seen by every register file instance.
    typedef enum logic [2:0] {
        WARP_IDLE    = 3'd0,
        WARP_FETCH   = 3'd1,
        WARP_DECODE  = 3'd2,
        WARP_REQUEST = 3'd3,
        WARP_WAIT    = 3'd4,
        WARP_EXECUTE = 3'd5,
        WARP_UPDATE  = 3'd6,
        WARP_DONE    = 3'd7
    } warp_state_t;

    // Scheduler FSM; SELECT has no register-file counterpart.
    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_REQUEST = 4'd3,
        S_WAIT    = 4'd4,
        S_EXECUTE = 4'd5,
        S_UPDATE  = 4'd6,
        S_SELECT  = 4'd7,
        S_DONE    = 4'd8
    } sched_state_t;

    function automatic warp_state_t stage_of(input sched_state_t s);
        case (s)
            S_FETCH:   return WARP_FETCH;
            S_DECODE:  return WARP_DECODE;
            S_REQUEST: return WARP_REQUEST;
            S_WAIT:    return WARP_WAIT;
            S_EXECUTE: return WARP_EXECUTE;
            S_UPDATE:  return WARP_UPDATE;
            S_DONE:    return WARP_DONE;
            default:   return WARP_IDLE;
        endcase
    endfunction

    // True in the stages where the current warp's register file is enabled.
    function automatic logic stage_has_warp(input sched_state_t s);
        return (s == S_FETCH)   || (s == S_DECODE)  || (s == S_REQUEST) ||
               (s == S_WAIT)    || (s == S_EXECUTE) || (s == S_UPDATE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/warp_scheduler_rr_picker.sv
// ============================================================================
//  Module      : warp_scheduler_rr_picker
//  Description : Combinational round-robin picker. Returns the runnable warp
//                closest after cur_i (wrapping), with cur_i itself last.
//  Ports       : runnable_i - runnable mask, one bit per warp
//                cur_i      - warp that just finished an instruction
//                idx_o      - selected warp index
//                found_o    - 1 when any warp is runnable
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module warp_scheduler_rr_picker
    import warp_scheduler_pkg::*;
#(
    parameter int WARPS_PER_CORE = 4,
    parameter int IDX_W          = 2
) (
    input  logic [WARPS_PER_CORE-1:0] runnable_i,
    input  logic [IDX_W-1:0]          cur_i,
    output logic [IDX_W-1:0]          idx_o,
    output logic                      found_o
);

    logic [IDX_W-1:0] cand;

    // Walk from the farthest distance to the nearest so the nearest runnable
    // candidate is the last one written and therefore wins.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        cand    = '0;
        for (int d = WARPS_PER_CORE; d >= 1; d--) begin
            cand = IDX_W'((int'(cur_i) + d) % WARPS_PER_CORE);
            if (runnable_i[cand]) begin
                idx_o   = cand;
                found_o = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/warp_scheduler.sv
// ============================================================================
//  Module      : warp_scheduler
//  Description : Single-issue warp scheduler. Steps the current warp through
//                FETCH/DECODE/REQUEST/(WAIT)/EXECUTE/UPDATE, then picks the
//                next runnable warp round-robin. Signals done once every
//                launched warp has halted.
//  Ports       : clk, reset (sync, active-low)
//                start, active_warps       - launch control
//                fetch_req/fetch_pc/fetch_valid - fetcher handshake
//                decoded_halt, decoded_mem_access - decoder results
//                lsu_req/lsu_done          - LSU handshake
//                next_pc                   - PC written back in UPDATE
//                warp_enable, cur_warp, warp_state - register file controls
//                done                      - all launched warps halted
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module warp_scheduler
    import warp_scheduler_pkg::*;
#(
    parameter int WARPS_PER_CORE = 4,
    parameter int DATA_WIDTH     = `DATA_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [$clog2(WARPS_PER_CORE+1)-1:0]   active_warps,
    output logic                                  fetch_req,
    output logic [DATA_WIDTH-1:0]                 fetch_pc,
    input  logic                                  fetch_valid,
    input  logic                                  decoded_halt,
    input  logic                                  decoded_mem_access,
    output logic                                  lsu_req,
    input  logic                                  lsu_done,
    input  logic [DATA_WIDTH-1:0]                 next_pc,
    output logic [WARPS_PER_CORE-1:0]             warp_enable,
    output logic [$clog2(WARPS_PER_CORE)-1:0]     cur_warp,
    output warp_state_t                           warp_state,
    output logic                                  done
);

    localparam int IDX_W = $clog2(WARPS_PER_CORE);
    localparam int CNT_W = $clog2(WARPS_PER_CORE+1);

    sched_state_t              state_q, state_d;
    logic [IDX_W-1:0]          cur_warp_q, cur_warp_d;
    logic [WARPS_PER_CORE-1:0] runnable_q, runnable_d;
    logic [DATA_WIDTH-1:0]     pc_q [WARPS_PER_CORE];

    logic                      fetch_req_q;
    logic [DATA_WIDTH-1:0]     fetch_pc_q;
    logic                      lsu_req_q;
    logic [WARPS_PER_CORE-1:0] warp_enable_q;
    warp_state_t               warp_state_q;
    logic                      done_q;

    logic [WARPS_PER_CORE-1:0] launch_mask;
    logic [IDX_W-1:0]          pick_idx;
    logic                      pick_found;

    // Bit i set when i < active_warps; requests above WARPS_PER_CORE clamp
    // naturally because every bit is then set.
    always_comb begin
        launch_mask = '0;
        for (int i = 0; i < WARPS_PER_CORE; i++) begin
            launch_mask[i] = (CNT_W'(i) < active_warps);
        end
    end

    warp_scheduler_rr_picker #(
        .WARPS_PER_CORE (WARPS_PER_CORE),
        .IDX_W          (IDX_W)
    ) u_picker (
        .runnable_i (runnable_q),
        .cur_i      (cur_warp_q),
        .idx_o      (pick_idx),
        .found_o    (pick_found)
    );

    always_comb begin
        state_d    = state_q;
        cur_warp_d = cur_warp_q;
        runnable_d = runnable_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (|launch_mask) begin
                        runnable_d = launch_mask;
                        cur_warp_d = '0;
                        state_d    = S_FETCH;
                    end else begin
                        state_d    = S_DONE;
                    end
                end
            end
            S_FETCH:   if (fetch_valid) state_d = S_DECODE;
            S_DECODE: begin
                if (decoded_halt) begin
                    runnable_d[cur_warp_q] = 1'b0;
                    state_d                = S_SELECT;
                end else begin
                    state_d                = S_REQUEST;
                end
            end
            S_REQUEST: state_d = decoded_mem_access ? S_WAIT : S_EXECUTE;
            S_WAIT:    if (lsu_done) state_d = S_EXECUTE;
            S_EXECUTE: state_d = S_UPDATE;
            S_UPDATE:  state_d = S_SELECT;
            S_SELECT: begin
                if (pick_found) begin
                    cur_warp_d = pick_idx;
                    state_d    = S_FETCH;
                end else begin
                    state_d    = S_DONE;
                end
            end
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs are computed from the next state so they are flops that line
    // up with state_q.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            cur_warp_q    <= '0;
            runnable_q    <= '0;
            for (int i = 0; i < WARPS_PER_CORE; i++) begin
                pc_q[i] <= '0;
            end
            fetch_req_q   <= 1'b0;
            fetch_pc_q    <= '0;
            lsu_req_q     <= 1'b0;
            warp_enable_q <= '0;
            warp_state_q  <= WARP_IDLE;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_warp_q    <= cur_warp_d;
            runnable_q    <= runnable_d;
            if (state_q == S_UPDATE) begin
                pc_q[cur_warp_q] <= next_pc;
            end
            fetch_req_q   <= (state_d == S_FETCH);
            fetch_pc_q    <= pc_q[cur_warp_d];
            lsu_req_q     <= (state_d == S_WAIT);
            warp_enable_q <= stage_has_warp(state_d)
                             ? (WARPS_PER_CORE'(1) << cur_warp_d) : '0;
            warp_state_q  <= stage_of(state_d);
            done_q        <= (state_d == S_DONE);
        end
    end

    assign fetch_req   = fetch_req_q;
    assign fetch_pc    = fetch_pc_q;
    assign lsu_req     = lsu_req_q;
    assign warp_enable = warp_enable_q;
    assign cur_warp    = cur_warp_q;
    assign warp_state  = warp_state_q;
    assign done        = done_q;

endmodule

`default_nettype wire

// File: doc/warp_scheduler.md
Name: warp_scheduler

Overview:
- Single-issue scheduler that sequences the warps of one core through the execution pipeline and drives the per-warp register file controls (enable, warp_state).
- Holds one PC per warp and picks the next runnable warp round-robin after each instruction.
- Handshakes with the fetcher and the LSU, and reports completion when every launched warp has halted.

Parameters:
- WARPS_PER_CORE, 4, number of warps managed; one register file instance per warp.
- DATA_WIDTH, `DATA_WIDTH, PC and next_pc width.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-low; 0 = reset.
- start  input  1  launch pulse; sampled only in IDLE.
- active_warps  input  $clog2(WARPS_PER_CORE+1)  number of warps to launch (warps 0..n-1).
- fetch_req  output  1  instruction fetch request for cur_warp.
- fetch_pc  output  DATA_WIDTH  pc of cur_warp; valid while fetch_req=1.
- fetch_valid  input  1  fetched instruction ready.
- decoded_halt  input  1  decoded instruction is HALT; sampled in DECODE.
- decoded_mem_access  input  1  decoded instruction is a load/store; sampled in REQUEST.
- lsu_req  output  1  LSU operation request for cur_warp.
- lsu_done  input  1  LSU operation complete.
- next_pc  input  DATA_WIDTH  computed next PC; sampled in UPDATE.
- warp_enable  output  WARPS_PER_CORE  one-hot enable to the register files.
- cur_warp  output  $clog2(WARPS_PER_CORE)  index of the warp being sequenced.
- warp_state  output  warp_state_t  current pipeline stage, broadcast to all register files.
- done  output  1  all launched warps halted.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE.
  - Outputs: fetch_req, lsu_req, warp_enable, cur_warp and done = 0; warp_state=WARP_IDLE.
  - All pc[i]=0; runnable mask=0.
  - Reset mid-operation aborts immediately; no pc update occurs.
- IDLE:
  - start=1 and active_warps>0: runnable mask = low min(active_warps, WARPS_PER_CORE) bits; cur_warp=0; done=0; next state FETCH.
  - start=1 and active_warps=0: go directly to DONE.
  - start=0: stay in IDLE.
- FETCH:
  - fetch_req=1 and fetch_pc=pc[cur_warp], held level until fetch_valid.
  - fetch_valid in the same cycle fetch_req first rises is legal; next state DECODE.
- DECODE: one cycle.
  - decoded_halt=1: clear runnable[cur_warp], go to SELECT.
  - Otherwise go to REQUEST.
- REQUEST: one cycle; register file latches rs1/rs2.
  - decoded_mem_access=1: go to WAIT. Otherwise go to EXECUTE.
- WAIT:
  - lsu_req=1 held until lsu_done; then go to EXECUTE.
  - lsu_done and lsu_req in the same cycle count as completion.
- EXECUTE: one cycle; then go to UPDATE.
- UPDATE: one cycle; register file writes rd; pc[cur_warp]<=next_pc; then go to SELECT.
- SELECT: one cycle; warp_state output = WARP_IDLE.
  - Choose the lowest-distance runnable warp starting at (cur_warp+1) mod WARPS_PER_CORE, wrapping around; cur_warp itself is eligible last.
  - A warp is found: go to FETCH.
  - No warp is runnable: go to DONE.
- DONE:
  - done=1 and warp_state=WARP_DONE, held.
  - start=1 re-launches as in IDLE; pc values are retained, not zeroed.
- warp_enable:
  - = 1<<cur_warp in FETCH, DECODE, REQUEST, WAIT, EXECUTE and UPDATE.
  - 0 in IDLE, SELECT and DONE.
- Signals ignored outside their states: fetch_valid outside FETCH, lsu_done outside WAIT, start outside IDLE/DONE.
- Minimum instruction latency with fetch_valid immediate is 6 cycles (FETCH..UPDATE + SELECT); add 1 for WAIT plus the LSU latency.
- All outputs are registered.

Decomposition:
- Shared package:
  - warp_state_t enum: WARP_IDLE, WARP_FETCH, WARP_DECODE, WARP_REQUEST, WARP_WAIT, WARP_EXECUTE, WARP_UPDATE, WARP_DONE.
  - data_t.
- Sub-module rr_picker (combinational): inputs runnable mask and cur_warp; outputs next index and found flag.

Test Plan:
- Reset: hold reset=0 for 2 cycles with start=1 -> all outputs 0, warp_state=WARP_IDLE, done=0.
- Single warp: active_warps=1, fetch_valid immediate, next_pc=pc+4, 3 non-mem instructions then HALT -> pc 0,4,8,12 fetched; warp_enable=0001 during stages; done=1 after the HALT's SELECT.
- Round-robin: active_warps=3, no halts for 6 instructions -> cur_warp sequence 0,1,2,0,1,2.
- Halt skipping: warp 1 halts first -> subsequent order 0,2,0,2 until both halt; then done=1.
- Memory wait: decoded_mem_access=1, lsu_done after 5 cycles -> lsu_req high exactly 5 cycles in WARP_WAIT; pc unchanged until UPDATE.
- Edge cases:
  - active_warps=0 with start -> done=1 next cycle.
  - active_warps=7 with WARPS_PER_CORE=4 -> clamped to 4 warps.
  - reset=0 during WAIT -> IDLE next cycle, lsu_req=0.
